// File: rtl/inverse_ip_tx.sv
// Final permutation (inverse initial permutation) of a 64-bit block, streamed MSB byte first
// toward a UART transmitter through a valid/ready handshake.
module inverse_ip_tx #(
    parameter bit SWAP = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CHIP_SELECT_BAR,
    input  logic [31:0] LEFT_IN,
    input  logic [31:0] RIGHT_IN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY
);

    localparam int unsigned BLK_W  = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(7);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLK_W-1:0]    buf_q, buf_d;
    logic                tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic [BLK_W-1:0]    fp_in;
    logic [BLK_W-1:0]    fp_out;
    logic                accept;

    // Destination position (64 = MSB) of input bit k under the inverse initial permutation.
    function automatic int unsigned fp_pos(input int unsigned k);
        int unsigned g;
        int unsigned j;
        g = (k - 1) / 8;
        j = (k - 1) % 8;
        return (g < 4) ? (58 + 2 * g - 8 * j) : (49 + 2 * g - 8 * j);
    endfunction

    assign fp_in = SWAP ? {RIGHT_IN, LEFT_IN} : {LEFT_IN, RIGHT_IN};

    // Pure wiring: every output bit is driven by exactly one input bit.
    always_comb begin
        fp_out = '0;
        for (int unsigned k = 1; k <= BLK_W; k++) begin
            fp_out[6'(fp_pos(k) - 1)] = fp_in[6'(k - 1)];
        end
    end

    // Ready is withheld during reset so a held IN_VALID cannot slip a block in.
    assign IN_READY = !RESET && (state_q == IDLE) && !CHIP_SELECT_BAR;
    assign accept   = IN_VALID && IN_READY;

    // Next-state logic; abort outranks the byte handshake, including on the last byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = fp_out;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (CHIP_SELECT_BAR) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (TX_READY) begin
                    if (cnt_q == LAST_BYTE) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d == SEND);
        tx_data_d  = tx_valid_d ? buf_d[{LAST_BYTE - cnt_d, 3'b000} +: BYTE_W] : '0;
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_VALID = tx_valid_q;
    assign TX_DATA  = tx_data_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_inverse_ip_tx.sv
// Bench for inverse_ip_tx: one SWAP=0 and one SWAP=1 instance fed exchanged halves,
// checked against a textbook initial-permutation table used as the inverse model.
module tb_inverse_ip_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        csb;
    logic        in_valid;
    logic        tx_ready;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic        in_ready0, in_ready1;
    logic        tx_valid0, tx_valid1;
    logic        busy0, busy1;
    logic [7:0]  tx_data0, tx_data1;
    logic [5:0]  ctrl;
    logic [15:0] data2;

    int n_checks = 0;
    int n_fail   = 0;

    // Initial permutation, textbook numbering (1 = MSB): output bit i takes input bit ip_tab[i-1].
    int unsigned ip_tab [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    always #5 clk = ~clk;

    inverse_ip_tx #(.SWAP(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .CHIP_SELECT_BAR(csb),
        .LEFT_IN(l_in), .RIGHT_IN(r_in), .IN_VALID(in_valid), .IN_READY(in_ready0),
        .TX_DATA(tx_data0), .TX_VALID(tx_valid0), .TX_READY(tx_ready), .BUSY(busy0)
    );

    inverse_ip_tx #(.SWAP(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .CHIP_SELECT_BAR(csb),
        .LEFT_IN(r_in), .RIGHT_IN(l_in), .IN_VALID(in_valid), .IN_READY(in_ready1),
        .TX_DATA(tx_data1), .TX_VALID(tx_valid1), .TX_READY(tx_ready), .BUSY(busy1)
    );

    assign ctrl  = {tx_valid0, tx_valid1, busy0, busy1, in_ready0, in_ready1};
    assign data2 = {tx_data0, tx_data1};

    function automatic logic [63:0] ip_model(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[6'(63 - i)] = x[6'(64 - int'(ip_tab[i]))];
        end
        return y;
    endfunction

    // Offer one block, then walk its 8 bytes with random stalls; optionally abort at byte abort_at.
    task automatic send_block(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp,
                              input int max_stall, input int abort_at, input bit use_reset,
                              input string tag);
        logic [7:0] eb;
        int         stall;
        @(negedge clk);
        l_in = l; r_in = r; in_valid = 1'b1; csb = 1'b0; tx_ready = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 6'b000011) begin
            n_fail++;
            $display("FAIL %s accept: ctrl=%b expected 000011", tag, ctrl);
        end
        @(negedge clk);
        in_valid = 1'b0; l_in = $urandom; r_in = $urandom;
        for (int b = 0; b < 8; b++) begin
            eb = 8'(exp >> (8 * (7 - b)));
            if (b == abort_at) begin
                tx_ready = 1'b1; in_valid = 1'b1;
                if (use_reset) rst = 1'b1;
                else csb = 1'b1;
                #1;
                n_checks++;
                if (data2 !== {eb, eb} || ctrl !== 6'b111100) begin
                    n_fail++;
                    $display("FAIL %s abort_cycle byte %0d: data=%h ctrl=%b expected %h%h 111100",
                             tag, b, data2, ctrl, eb, eb);
                end
                @(negedge clk);
                for (int c = 0; c < 2; c++) begin
                    n_checks++;
                    if (ctrl !== 6'b000000 || data2 !== 16'h0000) begin
                        n_fail++;
                        $display("FAIL %s after_abort cycle %0d: ctrl=%b data=%h expected 000000 0000",
                                 tag, c, ctrl, data2);
                    end
                    @(negedge clk);
                end
                rst = 1'b0; csb = 1'b0; in_valid = 1'b0; tx_ready = 1'b0;
                return;
            end
            stall = int'($urandom_range(max_stall, 0));
            for (int s = 0; s <= stall; s++) begin
                tx_ready = (s == stall);
                #1;
                n_checks++;
                if (data2 !== {eb, eb}) begin
                    n_fail++;
                    $display("FAIL %s byte %0d stall %0d: tx_data=%h expected %h%h", tag, b, s, data2, eb, eb);
                end
                n_checks++;
                if (ctrl !== 6'b111100) begin
                    n_fail++;
                    $display("FAIL %s ctrl byte %0d stall %0d: ctrl=%b expected 111100", tag, b, s, ctrl);
                end
                @(negedge clk);
                l_in = $urandom; r_in = $urandom;
            end
        end
        tx_ready = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 6'b000011 || data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s done: ctrl=%b data=%h expected 000011 0000", tag, ctrl, data2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; csb = 1'b0; in_valid = 1'b1; tx_ready = 1'b1;
        l_in = $urandom; r_in = $urandom;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ctrl !== 6'b000000 || data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: ctrl=%b data=%h expected 000000 0000", ctrl, data2);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 6'b000011 || data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: ctrl=%b data=%h expected 000011 0000", ctrl, data2);
        end
    endtask

    task automatic test_directed();
        logic [63:0] x;
        logic [63:0] ip;
        send_block(32'h0000_0000, 32'h0000_0001, 64'h0200_0000_0000_0000, 0, -1, 1'b0, "right_lsb");
        send_block(32'h8000_0000, 32'h0000_0000, 64'h0000_0000_0000_0040, 0, -1, 1'b0, "left_msb");
        x  = 64'h0123_4567_89AB_CDEF;
        ip = ip_model(x);
        send_block(ip[63:32], ip[31:0], x, 0, -1, 1'b0, "round_trip");
    endtask

    task automatic test_random_stalls();
        logic [63:0] x;
        logic [63:0] ip;
        for (int n = 0; n < 12; n++) begin
            x  = {$urandom, $urandom};
            ip = ip_model(x);
            send_block(ip[63:32], ip[31:0], x, 5, -1, 1'b0, "stall");
        end
    endtask

    // IN_VALID held high with fresh data every cycle: blocks must be taken every 9th cycle.
    task automatic test_back_to_back();
        logic [63:0] x_cur;
        logic [63:0] x_blk;
        logic [63:0] ip;
        logic [7:0]  eb;
        logic [5:0]  ec;
        int          ph;
        x_blk = '0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            x_cur = {$urandom, $urandom};
            ip = ip_model(x_cur);
            l_in = ip[63:32]; r_in = ip[31:0]; in_valid = 1'b1; tx_ready = 1'b1; csb = 1'b0;
            #1;
            ph = i % 9;
            ec = (ph == 0) ? 6'b000011 : 6'b111100;
            eb = (ph == 0) ? 8'h00 : 8'(x_blk >> (8 * (8 - ph)));
            n_checks++;
            if (ctrl !== ec || data2 !== {eb, eb}) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: ctrl=%b data=%h expected %b %h%h", i, ctrl, data2, ec, eb, eb);
            end
            if (ph == 0) x_blk = x_cur;
        end
        @(negedge clk);
        in_valid = 1'b0; tx_ready = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 6'b000011 || data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_drain: ctrl=%b data=%h expected 000011 0000", ctrl, data2);
        end
    endtask

    task automatic test_abort();
        logic [63:0] x;
        logic [63:0] ip;
        for (int a = 0; a < 2; a++) begin
            x  = {$urandom, $urandom};
            ip = ip_model(x);
            send_block(ip[63:32], ip[31:0], x, 2, (a == 0) ? 3 : 7, 1'b0, "abort");
            x  = {$urandom, $urandom};
            ip = ip_model(x);
            send_block(ip[63:32], ip[31:0], x, 1, -1, 1'b0, "post_abort");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] x;
        logic [63:0] ip;
        x  = {$urandom, $urandom};
        ip = ip_model(x);
        send_block(ip[63:32], ip[31:0], x, 2, 5, 1'b1, "mid_reset");
        x  = {$urandom, $urandom};
        ip = ip_model(x);
        send_block(ip[63:32], ip[31:0], x, 1, -1, 1'b0, "post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; csb = 1'b0; in_valid = 1'b0; tx_ready = 1'b0; l_in = '0; r_in = '0;
        test_reset();
        test_directed();
        test_random_stalls();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inverse_ip_tx.md
INVERSE_IP_TX -- requirements
Module: inverse_ip_tx

Interface
REQ-001 Parameter SWAP, default 1: 1 means the pre-output block is {RIGHT_IN, LEFT_IN}; 0 means it is {LEFT_IN, RIGHT_IN}.
REQ-002 Port CLK, input, 1: single clock, all state on rising edge.
REQ-003 Port RESET, input, 1: reset is synchronous and active-high.
REQ-004 Port CHIP_SELECT_BAR, input, 1: active-low block select; high blocks acceptance and aborts transfers.
REQ-005 Port LEFT_IN, input, 32: left half of the final-round block.
REQ-006 Port RIGHT_IN, input, 32: right half of the final-round block.
REQ-007 Port IN_VALID, input, 1: block offered on LEFT_IN/RIGHT_IN.
REQ-008 Port IN_READY, output, 1: block accepted on edge where IN_VALID=1 and IN_READY=1.
REQ-009 Port TX_DATA, output, 8: byte toward UART transmitter.
REQ-010 Port TX_VALID, output, 1: TX_DATA valid.
REQ-011 Port TX_READY, input, 1: byte consumed on edge where TX_VALID=1 and TX_READY=1.
REQ-012 Port BUSY, output, 1: high while in SEND.

Function
REQ-013 The block SHALL be indexed 64..1 (bit 64 = MSB), with FP_IN[64:33] the first half per REQ-001.
REQ-014 The block SHALL compute FP_OUT = inverse initial permutation: for k=1..64, g=(k-1) div 8, j=(k-1) mod 8, p(k) = (g<4 ? 58+2g : 49+2g) - 8j; FP_OUT[p(k)] = FP_IN[k].
REQ-015 REQ-014 SHALL satisfy: feeding the team's initial-permutation outputs LEFT/RIGHT of X with SWAP=0 reproduces X.
REQ-016 FSM states SHALL be IDLE and SEND only; a 3-bit byte counter CNT SHALL index bytes.
REQ-017 In IDLE, IN_READY SHALL equal NOT CHIP_SELECT_BAR; in SEND, IN_READY SHALL be 0.
REQ-018 On acceptance, FP_OUT SHALL be registered into a 64-bit buffer, CNT set to 0, and state set to SEND.
REQ-019 In SEND, TX_VALID SHALL be 1 and TX_DATA SHALL equal buffer byte CNT: CNT=0 -> bits 64:57, ..., CNT=7 -> bits 8:1.
REQ-020 The first byte SHALL appear with TX_VALID=1 in the cycle after the acceptance edge (latency 1).
REQ-021 TX_DATA SHALL hold stable while TX_VALID=1 and TX_READY=0, for any stall length.
REQ-022 On a TX handshake with CNT<7, CNT SHALL increment; with CNT=7, state SHALL return to IDLE and TX_VALID SHALL drop the next cycle.
REQ-023 Back-to-back blocks: IN_READY SHALL rise no earlier than the cycle after the final byte handshake; minimum block period is 9 cycles.
REQ-024 In IDLE, TX_VALID=0 and TX_DATA=8'h00.
REQ-025 CHIP_SELECT_BAR=1 during SEND SHALL abort: next cycle state IDLE, TX_VALID=0, TX_DATA=0, buffer discarded.
REQ-026 An abort SHALL take priority over a simultaneous TX handshake, including on CNT=7.
REQ-027 Input halves SHALL be sampled only on the acceptance edge; later changes SHALL not affect the buffer.
REQ-028 BUSY SHALL be 1 exactly when state is SEND.

Reset
REQ-029 RESET=1 at a rising edge SHALL force state IDLE, CNT=0, buffer=0, TX_VALID=0, TX_DATA=0, BUSY=0, regardless of other inputs.
REQ-030 IN_READY SHALL be 0 in every cycle RESET is 1; reset mid-SEND discards the block, and no further bytes follow.
REQ-031 Reset SHALL take priority over acceptance, handshake and abort in the same cycle.

Verification
REQ-032 SWAP=0, LEFT_IN=0, RIGHT_IN=32'h00000001, TX_READY=1 -> bytes 02,00,00,00,00,00,00,00, then TX_VALID=0.
REQ-033 SWAP=0, LEFT_IN=32'h80000000, RIGHT_IN=0 -> bytes 00,00,00,00,00,00,00,40.
REQ-034 Round trip: X=64'h0123456789ABCDEF through the initial-permutation block into LEFT_IN/RIGHT_IN, SWAP=0 -> bytes 01,23,45,67,89,AB,CD,EF; SWAP=1 with halves exchanged -> same bytes.
REQ-035 Random TX_READY stalls of 0-5 cycles per byte -> TX_DATA stable during each stall, exactly 8 handshakes, IN_READY=0 until after the last handshake.
REQ-036 CHIP_SELECT_BAR high after byte 3 -> next cycle TX_VALID=0, BUSY=0; the next accepted block starts at byte 0.
REQ-037 RESET asserted during byte 5 -> next cycle all outputs 0; IN_VALID held high during reset -> no acceptance until RESET=0.
